// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential 11-digit BCD to 36-bit binary converter
//
// Converts a packed 11-digit BCD number to unsigned binary using one
// multiply-by-ten-and-add step per digit, most-significant digit first.
// The latency is fixed: done pulses 12 enabled edges after the start edge.
//
// Ports:
//   Clk          in   1   system clock, rising edge
//   Reset        in   1   asynchronous active-high reset
//   enable       in   1   clock enable; 0 freezes all state and outputs
//   start        in   1   conversion request, sampled in IDLE only
//   BCD0..BCD10  in   4   decimal digits, BCD0 = units, BCD10 = 10^10
//   data         out  36  binary result, held until the next done
//   done         out  1   one-enabled-cycle pulse when results update
//   busy         out  1   high whenever a conversion is in progress
//   overflow     out  1   result >= 2^36, valid with done
//   error        out  1   a captured digit was > 9, valid with done

module bcd_to_binary_seq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  BCD0,
  input  logic [3:0]  BCD1,
  input  logic [3:0]  BCD2,
  input  logic [3:0]  BCD3,
  input  logic [3:0]  BCD4,
  input  logic [3:0]  BCD5,
  input  logic [3:0]  BCD6,
  input  logic [3:0]  BCD7,
  input  logic [3:0]  BCD8,
  input  logic [3:0]  BCD9,
  input  logic [3:0]  BCD10,
  output logic [35:0] data,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [36:0]  acc_q, acc_d;
  logic [43:0]  sr_q, sr_d;
  logic         bad_q, bad_d;
  logic [35:0]  data_q, data_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;

  logic [43:0]  digits_in;
  logic         any_bad;
  logic [3:0]   cur_digit;
  logic [36:0]  acc_x10;

  assign digits_in = {BCD10, BCD9, BCD8, BCD7, BCD6, BCD5,
                      BCD4, BCD3, BCD2, BCD1, BCD0};

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (digits_in[i*4 +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // cnt selects the digit being folded in: 10 first (most significant), 0 last.
  assign cur_digit = sr_q[{cnt_q, 2'b00} +: 4];
  // The largest 11-digit input fits in 37 bits, so acc never wraps.
  assign acc_x10   = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    bad_d   = bad_q;
    data_d  = data_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    if (enable) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sr_d    = digits_in;
            bad_d   = any_bad;
            acc_d   = '0;
            cnt_d   = 4'd10;
            state_d = CONV;
          end
        end
        CONV: begin
          acc_d = acc_x10 + {33'd0, cur_digit};
          if (cnt_q == 4'd0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (bad_q) begin
            data_d = '0;
            ovf_d  = 1'b0;
            err_d  = 1'b1;
          end else begin
            data_d = acc_q[35:0];
            ovf_d  = acc_q[36];
            err_d  = 1'b0;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sr_q    <= '0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign data     = data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq

module tb_bcd_to_binary_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        enable;
  logic        start;
  logic [43:0] digs;
  logic [35:0] data;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  bcd_to_binary_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .enable   (enable),
    .start    (start),
    .BCD0     (digs[3:0]),
    .BCD1     (digs[7:4]),
    .BCD2     (digs[11:8]),
    .BCD3     (digs[15:12]),
    .BCD4     (digs[19:16]),
    .BCD5     (digs[23:20]),
    .BCD6     (digs[27:24]),
    .BCD7     (digs[31:28]),
    .BCD8     (digs[35:32]),
    .BCD9     (digs[39:36]),
    .BCD10    (digs[43:40]),
    .data     (data),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .error    (error)
  );

  typedef struct {
    string       name;
    logic [43:0] d;
    logic [35:0] exp_data;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] to_bcd(input longint unsigned v);
    logic [43:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: positional weighted sum, then the output rules.
  task automatic model(input logic [43:0] d, output logic [35:0] md,
                       output logic mo, output logic me);
    longint unsigned v, p;
    logic bad;
    v = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (d[i*4 +: 4] > 9) bad = 1'b1;
      v += longint'(d[i*4 +: 4]) * p;
      p *= 10;
    end
    if (bad) begin
      md = '0; mo = 1'b0; me = 1'b1;
    end else begin
      md = v[35:0]; mo = (v >= 64'd68719476736); me = 1'b0;
    end
  endtask

  // Starts one conversion and returns the number of edges from the start
  // edge to the edge at which done is seen (-1 on timeout).
  task automatic convert(input logic [43:0] d, output int lat);
    @(negedge Clk);
    digs  = d;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    digs  = 44'($urandom) ^ {$urandom, 12'h0};
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string nm, input logic [43:0] d,
                               input logic [35:0] ed, input logic eo, input logic ee);
    int lat;
    convert(d, lat);
    chk({nm, " latency"}, 64'(lat), 64'd12);
    chk({nm, " data"}, 64'(data), 64'(ed));
    chk({nm, " overflow"}, 64'(overflow), 64'(eo));
    chk({nm, " error"}, 64'(error), 64'(ee));
    chk({nm, " busy after done"}, 64'(busy), 64'd0);
    @(posedge Clk);
    #1;
    chk({nm, " done single cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [43:0] d;
    logic [35:0] md;
    logic        mo, me;
    int          first_done, n_done;
    int          dq[$];

    tbl[0] = '{"d650345768", to_bcd(64'd650345768), 36'd650345768, 1'b0, 1'b0};
    tbl[1] = '{"d56292734539", to_bcd(64'd56292734539), 36'd56292734539, 1'b0, 1'b0};
    tbl[2] = '{"d82298316283", to_bcd(64'd82298316283), 36'd13578839547, 1'b1, 1'b0};
    tbl[3] = '{"all_nines", {11{4'h9}}, 36'd31280523263, 1'b1, 1'b0};
    d = to_bcd(64'd98765432101);
    d[15:12] = 4'hC;
    tbl[4] = '{"bad_bcd3", d, 36'd0, 1'b0, 1'b1};
    tbl[5] = '{"after_error", to_bcd(64'd42), 36'd42, 1'b0, 1'b0};
    tbl[6] = '{"all_zero", 44'd0, 36'd0, 1'b0, 1'b0};

    Reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    digs   = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset data", 64'(data), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_and_check(tbl[i].name, tbl[i].d, tbl[i].exp_data, tbl[i].exp_ovf, tbl[i].exp_err);
    end

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 11; j++) d[j*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) d[$urandom_range(0, 10)*4 +: 4] = 4'($urandom_range(10, 15));
      model(d, md, mo, me);
      run_and_check("random", d, md, mo, me);
    end

    // Enable low for 5 edges mid-conversion; extra starts while busy.
    @(negedge Clk);
    digs  = to_bcd(64'd650345768);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    first_done = -1;
    n_done = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge Clk);
      #1;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == 1 || k == 10) start = 1'b1;
      if (k == 2 || k == 11) start = 1'b0;
      if (k == 3) enable = 1'b0;
      if (k == 8) enable = 1'b1;
      if (k == 17) chk("enable data", 64'(data), 64'd650345768);
    end
    chk("enable latency", 64'(first_done), 64'd17);
    chk("enable done count", 64'(n_done), 64'd1);

    // Reset in the middle of a conversion.
    @(negedge Clk);
    digs  = to_bcd(64'd777);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("midreset data", 64'(data), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset overflow", 64'(overflow), 64'd0);
    chk("midreset error", 64'(error), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk);
      #1;
      if (done) n_done++;
    end
    chk("midreset no done", 64'(n_done), 64'd0);
    run_and_check("post_reset", to_bcd(64'd1234593), 36'd1234593, 1'b0, 1'b0);

    // start held high: a conversion every 13 edges.
    @(negedge Clk);
    digs  = '0;
    start = 1'b1;
    @(posedge Clk);
    #1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge Clk);
      #1;
      if (done) dq.push_back(k);
      if (dq.size() == 3) start = 1'b0;
    end
    chk("held done count", 64'(dq.size()), 64'd3);
    if (dq.size() >= 3) begin
      chk("held first latency", 64'(dq[0]), 64'd12);
      chk("held period 1", 64'(dq[1] - dq[0]), 64'd13);
      chk("held period 2", 64'(dq[2] - dq[1]), 64'd13);
    end
    chk("held busy at end", 64'(busy), 64'd0);
    chk("held data", 64'(data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
